// File: rtl/counter_cmd_arbiter.sv
// Round-robin command arbiter driving one shared counter's control strobes for rep+1 cycles per command.
// Define CNT_ARB_FIXED_PRIO_EN for fixed lowest-index priority (no rotating pointer).
module counter_cmd_arbiter #(
    parameter int N     = 4,
    parameter int REQ_M = 4,
    parameter int REP_W = 4
) (
    input  logic                   C,
    input  logic                   R,
    input  logic [REQ_M-1:0]       req_valid,
    output logic [REQ_M-1:0]       req_ready,
    input  logic [3*REQ_M-1:0]     req_op,
    input  logic [N*REQ_M-1:0]     req_data,
    input  logic [REP_W*REQ_M-1:0] req_rep,
    output logic [REQ_M-1:0]       done,
    output logic                   err,
    output logic                   busy,
    output logic [2:0]             owner,
    output logic                   cnt_R,
    output logic                   cnt_L,
    output logic                   cnt_INC,
    output logic                   cnt_DEC,
    output logic                   cnt_SHL,
    output logic                   cnt_SHR,
    output logic [N-1:0]           cnt_D
);

    typedef enum logic {IDLE, ISSUE} state_t;

    localparam logic [REP_W-1:0] REP_ONE = REP_W'(1);

    state_t             state_reg;
    logic [5:0]         strb_reg;
    logic [N-1:0]       cnt_d_reg;
    logic [REQ_M-1:0]   done_reg;
    logic               err_reg;
    logic               busy_reg;
    logic [2:0]         owner_reg;
    logic [REP_W-1:0]   cnt_reg;
    logic [REP_W-1:0]   rep_reg;
    logic [REP_W-1:0]   cnt_inc;

    logic [2:0]         op_arr   [REQ_M];
    logic [N-1:0]       data_arr [REQ_M];
    logic [REP_W-1:0]   rep_arr  [REQ_M];

    logic [2:0]         win_idx;
    logic               win_valid;
    logic [REQ_M-1:0]   win_onehot;
    logic [REQ_M-1:0]   owner_onehot;
    logic [2:0]         sel_op;
    logic [N-1:0]       sel_data;
    logic [REP_W-1:0]   sel_rep;

    genvar gi;
    generate
        for (gi = 0; gi < REQ_M; gi++) begin : g_req
            assign op_arr[gi]       = req_op[3*gi +: 3];
            assign data_arr[gi]     = req_data[N*gi +: N];
            assign rep_arr[gi]      = req_rep[REP_W*gi +: REP_W];
            assign win_onehot[gi]   = win_valid && (win_idx == 3'(gi));
            assign owner_onehot[gi] = (owner_reg == 3'(gi));
        end
    endgenerate

`ifdef CNT_ARB_FIXED_PRIO_EN
    always_comb begin
        win_idx   = '0;
        win_valid = 1'b0;
        for (int k = REQ_M - 1; k >= 0; k--) begin
            if (req_valid[k]) begin
                win_idx   = 3'(k);
                win_valid = 1'b1;
            end
        end
    end
`else
    localparam logic [3:0] REQ_M4 = 4'(REQ_M);

    logic [2:0] ptr_reg;
    logic [7:0] valid_pad;
    logic [3:0] rr_idx;

    // Walk candidates farthest-first so the one closest after ptr is written last and wins.
    always_comb begin
        valid_pad              = '0;
        valid_pad[REQ_M-1:0]   = req_valid;
        win_idx                = '0;
        win_valid              = 1'b0;
        rr_idx                 = '0;
        for (int k = REQ_M; k >= 1; k--) begin
            rr_idx = {1'b0, ptr_reg} + 4'(k);
            if (rr_idx >= REQ_M4) begin
                rr_idx = rr_idx - REQ_M4;
            end
            if (valid_pad[rr_idx[2:0]]) begin
                win_idx   = rr_idx[2:0];
                win_valid = 1'b1;
            end
        end
    end
`endif

    always_comb begin
        sel_op   = '0;
        sel_data = '0;
        sel_rep  = '0;
        for (int j = 0; j < REQ_M; j++) begin
            if (win_idx == 3'(j)) begin
                sel_op   = op_arr[j];
                sel_data = data_arr[j];
                sel_rep  = rep_arr[j];
            end
        end
    end

    assign req_ready = (state_reg == IDLE && !R) ? win_onehot : '0;
    assign cnt_inc   = cnt_reg + REP_ONE;

    // Strobe vector bit order: [0]=R [1]=L [2]=INC [3]=DEC [4]=SHL [5]=SHR
    function automatic logic [5:0] op_strobe(input logic [2:0] op);
        case (op)
            3'd1:    return 6'b000010;
            3'd2:    return 6'b000100;
            3'd3:    return 6'b001000;
            3'd4:    return 6'b010000;
            3'd5:    return 6'b100000;
            3'd6:    return 6'b000001;
            default: return 6'b000000;
        endcase
    endfunction

    always_ff @(posedge C) begin
        if (R) begin
            state_reg <= IDLE;
            strb_reg  <= '0;
            cnt_d_reg <= '0;
            done_reg  <= '0;
            err_reg   <= 1'b0;
            busy_reg  <= 1'b0;
            owner_reg <= '0;
            cnt_reg   <= '0;
            rep_reg   <= '0;
`ifndef CNT_ARB_FIXED_PRIO_EN
            ptr_reg   <= 3'(REQ_M - 1);
`endif
        end else begin
            done_reg <= '0;
            err_reg  <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (win_valid) begin
                        state_reg <= ISSUE;
                        strb_reg  <= op_strobe(sel_op);
                        cnt_d_reg <= sel_data;
                        rep_reg   <= sel_rep;
                        cnt_reg   <= '0;
                        owner_reg <= win_idx;
                        busy_reg  <= 1'b1;
                        err_reg   <= (sel_op == 3'd7);
                        done_reg  <= (sel_rep == '0) ? win_onehot : '0;
`ifndef CNT_ARB_FIXED_PRIO_EN
                        ptr_reg   <= win_idx;
`endif
                    end
                end
                ISSUE: begin
                    // Compare before incrementing so rep = all-ones never wraps cnt.
                    if (cnt_reg == rep_reg) begin
                        state_reg <= IDLE;
                        strb_reg  <= '0;
                        busy_reg  <= 1'b0;
                    end else begin
                        cnt_reg <= cnt_inc;
                        if (cnt_inc == rep_reg) begin
                            done_reg <= owner_onehot;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign cnt_R   = strb_reg[0];
    assign cnt_L   = strb_reg[1];
    assign cnt_INC = strb_reg[2];
    assign cnt_DEC = strb_reg[3];
    assign cnt_SHL = strb_reg[4];
    assign cnt_SHR = strb_reg[5];
    assign cnt_D   = cnt_d_reg;
    assign done    = done_reg;
    assign err     = err_reg;
    assign busy    = busy_reg;
    assign owner   = owner_reg;

endmodule

// File: tb/tb_counter_cmd_arbiter.sv
// Bench for counter_cmd_arbiter: directed scenarios then random traffic, checked each cycle
// against a transaction-level model (remaining-cycle count, owner, priority pointer).
module tb_counter_cmd_arbiter;
    localparam int N     = 4;
    localparam int REQ_M = 4;
    localparam int REP_W = 4;

    logic                   C = 1'b0;
    logic                   R = 1'b1;
    logic [REQ_M-1:0]       req_valid = '0;
    logic [REQ_M-1:0]       req_ready;
    logic [3*REQ_M-1:0]     req_op = '0;
    logic [N*REQ_M-1:0]     req_data = '0;
    logic [REP_W*REQ_M-1:0] req_rep = '0;
    logic [REQ_M-1:0]       done;
    logic                   err, busy;
    logic [2:0]             owner;
    logic                   cnt_R, cnt_L, cnt_INC, cnt_DEC, cnt_SHL, cnt_SHR;
    logic [N-1:0]           cnt_D;

    counter_cmd_arbiter #(.N(N), .REQ_M(REQ_M), .REP_W(REP_W)) dut (
        .C(C), .R(R),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_data(req_data), .req_rep(req_rep),
        .done(done), .err(err), .busy(busy), .owner(owner),
        .cnt_R(cnt_R), .cnt_L(cnt_L), .cnt_INC(cnt_INC), .cnt_DEC(cnt_DEC),
        .cnt_SHL(cnt_SHL), .cnt_SHR(cnt_SHR), .cnt_D(cnt_D)
    );

    always #5 C = ~C;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Opcode -> {SHR,SHL,DEC,INC,L,R}
    logic [5:0] op_map [8] = '{6'd0, 6'd2, 6'd4, 6'd8, 6'd16, 6'd32, 6'd1, 6'd0};

    bit m_active = 0;
    int m_left   = 0;   // strobe cycles left, counting the current one
    int m_owner  = 0;
    int m_ptr    = REQ_M - 1;
    int m_op     = 0;
    int m_data   = 0;
    int m_err    = 0;
    int m_done   = 0;
    bit drop_mode = 1;

    function automatic int pick();
`ifdef CNT_ARB_FIXED_PRIO_EN
        for (int i = 0; i < REQ_M; i++)
            if (req_valid[i]) return i;
`else
        for (int k = 1; k <= REQ_M; k++) begin
            int i;
            i = (m_ptr + k) % REQ_M;
            if (req_valid[i]) return i;
        end
`endif
        return -1;
    endfunction

    task automatic set_req(input int i, input bit v, input int op, input int data, input int rep);
        req_valid[i]          = v;
        req_op[3*i +: 3]      = 3'(op);
        req_data[N*i +: N]    = N'(data);
        req_rep[REP_W*i +: REP_W] = REP_W'(rep);
    endtask

    task automatic step();
        int w;
        int rep_w;
        bit acc;
        #1;
        w   = pick();
        acc = (!R && !m_active && w >= 0);
        chk("req_ready", 32'(req_ready), acc ? (32'd1 << w) : 32'd0);
        if (R) begin
            m_active = 0; m_data = 0; m_owner = 0; m_ptr = REQ_M - 1; m_err = 0; m_done = 0;
        end else if (m_active) begin
            m_err = 0;
            if (m_left == 1) begin
                m_active = 0;
                m_done   = 0;
            end else begin
                m_left--;
                m_done = (m_left == 1) ? (1 << m_owner) : 0;
            end
        end else if (acc) begin
            m_op    = int'(req_op[3*w +: 3]);
            m_data  = int'(req_data[N*w +: N]);
            rep_w   = int'(req_rep[REP_W*w +: REP_W]);
            m_active = 1;
            m_left   = rep_w + 1;
            m_owner  = w;
            m_ptr    = w;
            m_err    = (m_op == 7) ? 1 : 0;
            m_done   = (rep_w == 0) ? (1 << w) : 0;
            $display("accept req %0d op %0d data %0h rep %0d at %0t", w, m_op, m_data, rep_w, $time);
        end else begin
            m_err = 0; m_done = 0;
        end
        @(posedge C);
        #1;
        if (acc && drop_mode) req_valid[w] = 1'b0;
        chk("strobes", 32'({cnt_SHR, cnt_SHL, cnt_DEC, cnt_INC, cnt_L, cnt_R}),
            m_active ? 32'(op_map[m_op]) : 32'd0);
        chk("cnt_D", 32'(cnt_D), 32'(m_data));
        chk("busy",  32'(busy),  32'(m_active));
        chk("done",  32'(done),  32'(m_done));
        chk("err",   32'(err),   32'(m_err));
        chk("owner", 32'(owner), 32'(m_owner));
    endtask

    initial begin
        R = 1'b1;
        repeat (3) step();
        R = 1'b0;

        // LOAD, rep 0
        set_req(0, 1, 1, 'hA, 0);
        repeat (3) step();
        // INC, rep 3 on requester 2
        set_req(2, 1, 2, 3, 3);
        repeat (7) step();
        // all requesters contending continuously
        for (int i = 0; i < REQ_M; i++) set_req(i, 1, 2, i, 0);
        drop_mode = 0;
        repeat (10) step();
        req_valid = '0;
        drop_mode = 1;
        repeat (2) step();
        // illegal opcode
        set_req(1, 1, 7, 5, 1);
        repeat (4) step();
        // long DEC aborted by reset in its 5th strobe cycle
        set_req(0, 1, 3, 7, 15);
        repeat (5) step();
        R = 1'b1;
        step();
        R = 1'b0;
        set_req(3, 1, 0, 9, 0);
        repeat (3) step();
        // CLR on requester 3 while requester 0 waits
        set_req(3, 1, 6, 2, 1);
        step();
        set_req(0, 1, 2, 1, 0);
        repeat (6) step();
        // maximum repeat count
        set_req(2, 1, 5, 'hF, 15);
        repeat (18) step();

        // random traffic
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < REQ_M; i++) begin
                if (!req_valid[i] && $urandom_range(0, 2) == 0)
                    set_req(i, 1, int'($urandom_range(0, 7)), int'($urandom_range(0, 15)),
                            ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15))
                                                        : int'($urandom_range(0, 2)));
                else if (req_valid[i] && $urandom_range(0, 19) == 0)
                    req_valid[i] = 1'b0;
            end
            R = ($urandom_range(0, 99) == 0);
            step();
        end
        R = 1'b0;
        req_valid = '0;
        repeat (20) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
